// File: rtl/tm_sr_dpr_rx_pkg.sv
// Shared master-protocol definitions: frame marker, command flags and the
// one-hot command encoding reported on rx_state.
package tm_sr_dpr_rx_pkg;

    localparam logic [7:0] MARKER_MASTER            = 8'hA5;
    localparam logic [7:0] FLAG_TIME_MARK           = 8'h01;
    localparam logic [7:0] FLAG_STATUS_REQUEST      = 8'h02;
    localparam logic [7:0] FLAG_DATA_PACKET_REQUEST = 8'h04;

    typedef enum logic [2:0] {
        CMD_NONE = 3'b000,
        CMD_TM   = 3'b001,
        CMD_SR   = 3'b010,
        CMD_DPR  = 3'b100
    } cmd_e;

    // Unknown flags map to CMD_NONE so the parser can reject them.
    function automatic cmd_e flag_to_cmd(input logic [7:0] flag);
        case (flag)
            FLAG_TIME_MARK:           return CMD_TM;
            FLAG_STATUS_REQUEST:      return CMD_SR;
            FLAG_DATA_PACKET_REQUEST: return CMD_DPR;
            default:                  return CMD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/tm_sr_dpr_rx_gap_timer.sv
// Inter-byte gap timer: counts idle cycles while enabled, expires at
// GAP_TIMEOUT-1 and saturates there instead of wrapping.
module tm_sr_dpr_rx_gap_timer #(
    parameter int GAP_TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int W = $clog2(GAP_TIMEOUT);
    localparam logic [W-1:0] LAST = W'(GAP_TIMEOUT - 1);

    logic [W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || !i_en) begin
            r_cnt <= '0;
        end else if (r_cnt != LAST) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // A byte arriving on the expiry cycle wins over the timeout.
    assign o_expire = i_en && !i_clr && (r_cnt == LAST);

endmodule

// File: rtl/tm_sr_dpr_rx.sv
// Slave receive parser for master frames {A5, flag, arg_hi, arg_lo}; emits a
// one-hot command strobe with its argument, or msg_err on an aborted frame.
module tm_sr_dpr_rx
    import tm_sr_dpr_rx_pkg::*;
#(
    parameter int GAP_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  d,
    input  logic        d_rdy,
    input  logic        d_err,
    output logic [2:0]  rx_state,
    output logic [15:0] arg,
    output logic        msg_err,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_FLAG,
        ST_WAIT_HI,
        ST_WAIT_LO
    } state_e;

    state_e      r_state,    w_state_nxt;
    cmd_e        r_cmd,      w_cmd_nxt;
    cmd_e        r_rx_state, w_rx_state_nxt;
    logic [7:0]  r_arg_hi,   w_arg_hi_nxt;
    logic [15:0] r_arg,      w_arg_nxt;
    logic        r_msg_err,  w_msg_err_nxt;
    cmd_e        w_cmd_dec;
    logic        w_expire;

    assign w_cmd_dec = flag_to_cmd(d);

    tm_sr_dpr_rx_gap_timer #(
        .GAP_TIMEOUT (GAP_TIMEOUT)
    ) u_gap_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (d_rdy),
        .i_en     (r_state != ST_IDLE),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cmd      <= CMD_NONE;
            r_rx_state <= CMD_NONE;
            r_arg_hi   <= '0;
            r_arg      <= '0;
            r_msg_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cmd      <= w_cmd_nxt;
            r_rx_state <= w_rx_state_nxt;
            r_arg_hi   <= w_arg_hi_nxt;
            r_arg      <= w_arg_nxt;
            r_msg_err  <= w_msg_err_nxt;
        end
    end

    // NOTE: every signal driven here gets a default first, so no latch can be inferred.
    always_comb begin
        w_state_nxt    = r_state;
        w_cmd_nxt      = r_cmd;
        w_rx_state_nxt = CMD_NONE;
        w_arg_hi_nxt   = r_arg_hi;
        w_arg_nxt      = r_arg;
        w_msg_err_nxt  = 1'b0;

        if (r_state == ST_IDLE) begin
            // Decoder errors and stray bytes outside a frame are ignored.
            if (d_rdy && !d_err && (d == MARKER_MASTER)) begin
                w_state_nxt = ST_WAIT_FLAG;
            end
        end else if (d_err) begin
            w_state_nxt   = ST_IDLE;
            w_msg_err_nxt = 1'b1;
        end else if (d_rdy) begin
            case (r_state)
                ST_WAIT_FLAG: begin
                    if (w_cmd_dec != CMD_NONE) begin
                        w_cmd_nxt   = w_cmd_dec;
                        w_state_nxt = ST_WAIT_HI;
                    end else begin
                        // A repeated marker restarts the frame instead of dropping it.
                        w_msg_err_nxt = 1'b1;
                        w_state_nxt   = (d == MARKER_MASTER) ? ST_WAIT_FLAG : ST_IDLE;
                    end
                end
                ST_WAIT_HI: begin
                    w_arg_hi_nxt = d;
                    w_state_nxt  = ST_WAIT_LO;
                end
                default: begin
                    w_arg_nxt      = {r_arg_hi, d};
                    w_rx_state_nxt = r_cmd;
                    w_state_nxt    = ST_IDLE;
                end
            endcase
        end else if (w_expire) begin
            w_state_nxt   = ST_IDLE;
            w_msg_err_nxt = 1'b1;
        end
    end

    assign rx_state = r_rx_state;
    assign arg      = r_arg;
    assign msg_err  = r_msg_err;
    assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_tm_sr_dpr_rx.sv
// Scoreboard bench for tm_sr_dpr_rx: each expected strobe is queued with the
// cycle it must appear in; a negedge monitor pops and compares.
module tb_tm_sr_dpr_rx;

    localparam int GAP = 8;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  d     = 8'h00;
    logic        d_rdy = 1'b0;
    logic        d_err = 1'b0;
    logic [2:0]  rx_state;
    logic [15:0] arg;
    logic        msg_err;
    logic        busy;

    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc_p       = 0;
    logic [15:0] exp_arg     = 16'h0000;

    typedef struct {
        logic [2:0]  rx;
        logic [15:0] arg;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    tm_sr_dpr_rx #(.GAP_TIMEOUT(GAP)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .d        (d),
        .d_rdy    (d_rdy),
        .d_err    (d_err),
        .rx_state (rx_state),
        .arg      (arg),
        .msg_err  (msg_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_p <= cyc_p + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if ((msg_err && rx_state != 3'b000) || $countones(rx_state) > 1) begin
                miscompares++;
                $display("FAIL strobe_exclusive: rx_state=%b msg_err=%b at cycle %0d", rx_state, msg_err, cyc_p);
            end
            if (rx_state != 3'b000 || msg_err) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_event: rx_state=%b msg_err=%b arg=%h at cycle %0d, none expected",
                             rx_state, msg_err, arg, cyc_p);
                end else begin
                    mon_e = sb.pop_front();
                    if (rx_state !== mon_e.rx || msg_err !== mon_e.err || arg !== mon_e.arg || cyc_p != mon_e.cyc) begin
                        miscompares++;
                        $display("FAIL event: got rx=%b err=%b arg=%h cyc=%0d, expected rx=%b err=%b arg=%h cyc=%0d",
                                 rx_state, msg_err, arg, cyc_p, mon_e.rx, mon_e.err, mon_e.arg, mon_e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_byte(input logic [7:0] b, input int gap);
        d     = b;
        d_rdy = 1'b1;
        @(negedge clk);
        d_rdy = 1'b0;
        d     = 8'h00;
        repeat (gap) @(negedge clk);
    endtask

    task automatic drive_err(input logic with_byte, input logic [7:0] b);
        d     = b;
        d_rdy = with_byte;
        d_err = 1'b1;
        @(negedge clk);
        d_err = 1'b0;
        d_rdy = 1'b0;
        d     = 8'h00;
    endtask

    task automatic push_exp(input logic [2:0] rx, input logic err, input int cyc);
        exp_t e;
        e.rx  = rx;
        e.arg = exp_arg;
        e.err = err;
        e.cyc = cyc;
        sb.push_back(e);
    endtask

    // The strobe appears one cycle after the last byte is sampled.
    task automatic send_good(input logic [7:0] flag, input logic [7:0] hi, input logic [7:0] lo,
                             input logic [2:0] rx, input int gap);
        drive_byte(8'hA5, gap);
        drive_byte(flag, gap);
        drive_byte(hi, gap);
        exp_arg = {hi, lo};
        push_exp(rx, 1'b0, cyc_p + 1);
        drive_byte(lo, 0);
    endtask

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL %s: %0d expected events never seen", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if (rx_state !== 3'b000 || arg !== 16'h0000 || msg_err !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: rx=%b arg=%h err=%b busy=%b, expected all zero", rx_state, arg, msg_err, busy);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (rx_state !== 3'b000 || arg !== 16'h0000 || msg_err !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL after_reset: rx=%b arg=%h err=%b busy=%b, expected all zero", rx_state, arg, msg_err, busy);
        end
    endtask

    task automatic test_time_mark();
        send_good(8'h01, 8'h12, 8'h34, 3'b001, 0);
        drain("time_mark", 5);
    endtask

    task automatic test_spaced_frame();
        logic [7:0] fr [4];
        fr = '{8'hA5, 8'h04, 8'h00, 8'h00};
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                exp_arg = 16'h0000;
                push_exp(3'b100, 1'b0, cyc_p + 1);
            end
            drive_byte(fr[i], 0);
            vectors++;
            if (busy !== (i < 3)) begin
                miscompares++;
                $display("FAIL spaced_busy_after_byte%0d: busy=%b, expected %b", i, busy, (i < 3));
            end
            if (i < 3) begin
                repeat (5) @(negedge clk);
                vectors++;
                if (busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL spaced_busy_in_gap%0d: busy=%b, expected 1", i, busy);
                end
            end
        end
        drain("spaced_frame", 5);
    endtask

    task automatic test_drop_leading();
        drive_byte(8'h33, 0);
        send_good(8'h02, 8'hAB, 8'hCD, 3'b010, 0);
        drain("drop_leading", 5);
    endtask

    task automatic test_bad_flag();
        drive_byte(8'hA5, 0);
        push_exp(3'b000, 1'b1, cyc_p + 1);
        drive_byte(8'h07, 0);
        drain("bad_flag", 5);
        drive_byte(8'hA5, 0);
        push_exp(3'b000, 1'b1, cyc_p + 1);
        drive_byte(8'hA5, 0);
        drive_byte(8'h01, 0);
        drive_byte(8'h00, 0);
        exp_arg = 16'h0005;
        push_exp(3'b001, 1'b0, cyc_p + 1);
        drive_byte(8'h05, 0);
        drain("marker_resync", 5);
    endtask

    task automatic test_decoder_error();
        for (int k = 0; k < 2; k++) begin
            drive_byte(8'hA5, 0);
            drive_byte(8'h01, 0);
            drive_byte(8'h12, 0);
            push_exp(3'b000, 1'b1, cyc_p + 1);
            drive_err(k[0], 8'h34);
            drain("decoder_error", 5);
            vectors++;
            if (arg !== exp_arg || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL derr_hold_%0d: arg=%h busy=%b, expected arg=%h busy=0", k, arg, busy, exp_arg);
            end
        end
        // In IDLE a decoder error is ignored and its byte discarded.
        drive_err(1'b1, 8'hA5);
        drive_byte(8'h01, 0);
        drive_byte(8'h12, 0);
        drive_byte(8'h34, 0);
        drain("idle_derr", 5);
    endtask

    task automatic test_timeout();
        drive_byte(8'hA5, 0);
        drive_byte(8'h02, 0);
        push_exp(3'b000, 1'b1, cyc_p + GAP);
        repeat (GAP - 1) @(negedge clk);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_before_expiry: busy=%b, expected 1", busy);
        end
        drain("timeout", GAP + 4);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_after_timeout: busy=%b, expected 0", busy);
        end
        // A byte landing exactly on the expiry cycle keeps the frame alive.
        drive_byte(8'hA5, 0);
        drive_byte(8'h02, GAP - 1);
        drive_byte(8'hAB, 0);
        exp_arg = 16'hABCD;
        push_exp(3'b010, 1'b0, cyc_p + 1);
        drive_byte(8'hCD, 0);
        drain("expiry_byte", 5);
    endtask

    task automatic test_back_to_back();
        send_good(8'h04, 8'h5A, 8'hC3, 3'b100, 0);
        send_good(8'h01, 8'hFF, 8'h00, 3'b001, 0);
        send_good(8'h02, 8'h80, 8'h01, 3'b010, 0);
        drain("back_to_back", 5);
    endtask

    task automatic test_reset_mid_frame();
        drive_byte(8'hA5, 0);
        drive_byte(8'h01, 0);
        drive_byte(8'h12, 0);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (rx_state !== 3'b000 || arg !== 16'h0000 || msg_err !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_frame: rx=%b arg=%h err=%b busy=%b, expected all zero", rx_state, arg, msg_err, busy);
        end
        sb.delete();
        exp_arg = 16'h0000;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive_byte(8'h34, 0);
        drain("reset_no_strobe", 5);
        send_good(8'h04, 8'h00, 8'h42, 3'b100, 0);
        drain("reset_recovery", 5);
    endtask

    initial begin
        test_reset();
        test_time_mark();
        test_spaced_frame();
        test_drop_leading();
        test_bad_flag();
        test_decoder_error();
        test_timeout();
        test_back_to_back();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tm_sr_dpr_rx.md
Name: tm_sr_dpr_rx

Overview:
Slave-side receive parser for the master command protocol (time mark, status request, data packet request). It takes decoded bytes from the line decoder and checks the 4-byte frame: MARKER_MASTER, flag, arg_hi, arg_lo. It reports the received command as a one-hot, one-cycle strobe with its 16-bit argument, and reports malformed or stalled frames on msg_err. It sits between the line decoder and the slave command/response logic.

Parameters:
MARKER_MASTER, 8'hA5, frame start byte; instantiated from msg_defs.vh.
FLAG_TIME_MARK, 8'h01, flag byte for time mark.
FLAG_STATUS_REQUEST, 8'h02, flag byte for status request.
FLAG_DATA_PACKET_REQUEST, 8'h04, flag byte for data packet request.
GAP_TIMEOUT, 1024, maximum clk cycles allowed between two byte strobes inside one frame; must be at least 2.

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
d  in  8  decoded byte; valid only while d_rdy=1.
d_rdy  in  1  one-cycle strobe, one per received byte.
d_err  in  1  one-cycle strobe; the decoder saw a code or parity error.
rx_state  out  3  one-cycle one-hot command strobe: [0]=TM, [1]=SR, [2]=DPR.
arg  out  16  {arg_hi,arg_lo} of the last good frame; held until the next good frame.
msg_err  out  1  one-cycle strobe: frame aborted.
busy  out  1  high while a frame is partially received (state other than IDLE).

Behaviour:
- Reset (async assert, sync release): state=IDLE, rx_state=0, arg=0, msg_err=0, busy=0, gap counter=0.
- FSM states: IDLE, WAIT_FLAG, WAIT_HI, WAIT_LO. Transitions happen only on d_rdy, d_err, or timeout.
- IDLE:
  - d_rdy with d==MARKER_MASTER -> WAIT_FLAG.
  - Any other byte is dropped silently (no msg_err).
  - d_err in IDLE is ignored.
- WAIT_FLAG:
  - d_rdy with d equal to one of the three flags -> latch the one-hot command, go to WAIT_HI.
  - d_rdy with d==MARKER_MASTER -> pulse msg_err, stay in WAIT_FLAG (resync).
  - Any other d -> pulse msg_err, go to IDLE.
- WAIT_HI: d_rdy -> latch arg_hi, go to WAIT_LO.
- WAIT_LO: d_rdy -> go to IDLE. On the next cycle, arg={arg_hi,d} and rx_state pulses the latched command for exactly 1 cycle.
- Latency: rx_state and the arg update appear 1 clk after the d_rdy of the 4th byte. arg changes in the same cycle as the rx_state pulse.
- d_err in WAIT_FLAG, WAIT_HI or WAIT_LO -> pulse msg_err 1 cycle later, go to IDLE. Any partial argument is discarded and arg is unchanged.
- d_err and d_rdy in the same cycle: d_err wins and the byte is discarded.
- Gap timer:
  - Clears on every d_rdy and counts while busy.
  - When the count reaches GAP_TIMEOUT-1 with no d_rdy -> msg_err pulse, go to IDLE.
  - Expiry and d_rdy in the same cycle: the byte wins and the timer clears.
  - Counter width is clog2(GAP_TIMEOUT). It saturates and never wraps.
- msg_err and rx_state are never high in the same cycle. At most one rx_state bit is set.
- Back-to-back frames: a marker may arrive on the cycle after the 4th byte; no idle gap is required.
- Reset mid-frame: all state is cleared immediately and no strobe is emitted.

Decomposition:
- Shared msg_defs.vh supplies MARKER_MASTER and the three FLAG_* values, also used by the master transmitter. The FSM state encodings stay local to the block.
- One natural sub-module, tm_sr_dpr_rx_gap_timer: clear, enable and expire pulse, parameterised by GAP_TIMEOUT.

Test Plan:
1. Bytes A5,01,12,34 on consecutive strobes -> rx_state=3'b001 for 1 cycle, 1 clk after the last strobe; arg=16'h1234; msg_err=0.
2. Bytes A5,04,00,00 with 5 idle cycles between strobes -> rx_state=3'b100 once; arg=0; busy high from the cycle after the first strobe until the cycle after the last strobe.
3. Bytes 33,A5,02,AB,CD -> 0x33 dropped silently; rx_state=3'b010; arg=16'hABCD; no msg_err.
4. Bytes A5,07 -> msg_err pulse, IDLE. Bytes A5,A5,01,00,05 -> msg_err on the second A5, then rx_state=3'b001 with arg=16'h0005.
5. Bytes A5,01,12, then d_err -> msg_err pulse, no rx_state, arg keeps its previous value. Repeat with d_err and d_rdy in the same cycle -> same result.
6. GAP_TIMEOUT=8: bytes A5,02 then silence -> msg_err exactly at count 7, busy drops. Repeat with a byte on the expiry cycle -> no error. Also assert rst_n low mid-frame -> all outputs 0 immediately.
